flash_read_seq: RTL and testbench

- Upstream sequencer for the flash access timer.
- Accepts a burst-read request of LEN bytes from the parallel NOR flash (8-bit mode) and drives the flash address and control strobes.
- For every byte it issues a one-cycle start pulse to the access timer, waits for the timer's done, then latches the data bus and presents the byte to the consumer (scoreboard data/font loader).
- Includes a watchdog, so a dead timer cannot hang the design.

---
 rtl/flash_read_seq.sv | 150 +++++++++++++++
 tb/tb_flash_read_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_read_seq.sv
// Burst-read sequencer for an 8-bit parallel NOR flash.
// Paces each byte through an external access timer and has a watchdog for a dead timer.
module flash_read_seq #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              CLK_50MHZ,
    input  logic              RST_N,
    input  logic              req,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              done,
    output logic              err,
    output logic              tmr_start,
    input  logic              tmr_done,
    output logic [ADDR_W-1:0] SF_A,
    input  logic [7:0]        SF_D,
    output logic              SF_CE0,
    output logic              SF_OE,
    output logic              SF_WE,
    output logic              SF_BYTE
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CAPTURE,
        S_FINISH,
        S_ABORT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ADDR_W-1:0] sf_a_q, sf_a_d;
    logic [7:0]        data_q, data_d;
    logic              dv_q, dv_d;
    logic              flash_on;

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wd_q    <= '0;
            sf_a_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wd_q    <= wd_d;
            sf_a_q  <= sf_a_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wd_d    = wd_q;
        sf_a_d  = sf_a_q;
        data_d  = data_q;
        dv_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (req) begin
                    addr_d = base_addr;
                    rem_d  = len;
                    if (len == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // A timer answer in the timeout cycle still completes the byte.
                if (tmr_done) begin
                    wd_d    = '0;
                    state_d = S_CAPTURE;
                end else if (wd_d == WD_LAST) begin
                    wd_d    = '0;
                    state_d = S_ABORT;
                end
            end
            S_CAPTURE: begin
                data_d = SF_D;
                dv_d   = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_SETUP;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address is loaded on entry to SETUP so it is stable for the whole access.
        if (state_d == S_SETUP) begin
            sf_a_d = addr_d;
        end
    end

    assign flash_on = (state_q == S_SETUP) ||
                      (state_q == S_WAIT) ||
                      (state_q == S_CAPTURE);

    assign busy       = (state_q != S_IDLE);
    assign tmr_start  = (state_q == S_SETUP);
    assign done       = (state_q == S_FINISH);
    assign err        = (state_q == S_ABORT);
    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign SF_A       = sf_a_q;
    assign SF_CE0     = ~flash_on;
    assign SF_OE      = ~flash_on;
    assign SF_WE      = 1'b1;
    assign SF_BYTE    = 1'b0;

endmodule

// File: tb/tb_flash_read_seq.sv
// Scoreboard bench for flash_read_seq with timer and flash models.
// Expected bytes/events are queued at request time; a monitor checks DUT output.
module tb_flash_read_seq;

    localparam int AW = 24;
    localparam int LW = 16;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic [7:0]    data_out;
    logic          data_valid;
    logic          done;
    logic          err;
    logic          tmr_start;
    logic          tmr_done;
    logic [AW-1:0] SF_A;
    logic [7:0]    SF_D;
    logic          SF_CE0;
    logic          SF_OE;
    logic          SF_WE;
    logic          SF_BYTE;

    flash_read_seq #(
        .ADDR_W (AW),
        .LEN_W  (LW),
        .TIMEOUT(TO)
    ) dut (
        .CLK_50MHZ (clk),
        .RST_N     (rst_n),
        .req       (req),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .data_out  (data_out),
        .data_valid(data_valid),
        .done      (done),
        .err       (err),
        .tmr_start (tmr_start),
        .tmr_done  (tmr_done),
        .SF_A      (SF_A),
        .SF_D      (SF_D),
        .SF_CE0    (SF_CE0),
        .SF_OE     (SF_OE),
        .SF_WE     (SF_WE),
        .SF_BYTE   (SF_BYTE)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 4;
    int t_cnt   = 0;

    logic [7:0]    exp_data[$];
    bit            exp_evt[$];
    logic [AW-1:0] sfa_log[$];
    int            dv_log[$];

    int n_start   = 0;
    int n_dv      = 0;
    int n_done    = 0;
    int n_err     = 0;
    int n_ce_low  = 0;
    int last_start = 0;
    int req_cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    assign SF_D = (!SF_CE0 && !SF_OE) ? (SF_A[7:0] ^ 8'hA5) : 8'hFF;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Access timer: done goes high 'lat' cycles after the start cycle.
    initial begin
        tmr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                t_cnt    = 0;
                tmr_done = 1'b0;
            end else if (tmr_start) begin
                t_cnt    = lat;
                tmr_done = 1'b0;
            end else if (t_cnt > 0) begin
                t_cnt--;
                tmr_done = (t_cnt == 0);
            end else begin
                tmr_done = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [7:0] e;
        bit         ev;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tmr_start) begin
                    n_start++;
                    last_start = cyc;
                    sfa_log.push_back(SF_A);
                end
                if (!SF_CE0) n_ce_low++;
                if (data_valid) begin
                    n_dv++;
                    dv_log.push_back(cyc);
                    if (exp_data.size() == 0) begin
                        chk("unexpected_data_valid", 1, 0);
                    end else begin
                        e = exp_data.pop_front();
                        chk("data_out", data_out, e);
                    end
                end
                if (done) begin
                    n_done++;
                    if (exp_evt.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        ev = exp_evt.pop_front();
                        chk("event_done", ev, 0);
                    end
                end
                if (err) begin
                    n_err++;
                    if (exp_evt.size() == 0) begin
                        chk("unexpected_err", 1, 0);
                    end else begin
                        ev = exp_evt.pop_front();
                        chk("event_err", ev, 1);
                    end
                end
            end
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input int l,
                               input int lt, input bit dead);
        logic [AW-1:0] a;
        @(negedge clk);
        lat = lt;
        req_cyc = cyc;
        if (!dead) begin
            for (int i = 0; i < l; i++) begin
                a = b + AW'(i);
                exp_data.push_back(a[7:0] ^ 8'hA5);
            end
        end
        exp_evt.push_back(dead);
        req       = 1'b1;
        base_addr = b;
        len       = LW'(l);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_end(output int c, output bit gd, output bit ge);
        bit found;
        found = 0;
        c  = 0;
        gd = 0;
        ge = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (done || err) begin
                found = 1;
                c  = cyc;
                gd = done;
                ge = err;
            end else begin
                @(negedge clk);
            end
        end
        if (!found) chk("burst_end_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c;
        bit gd;
        bit ge;
        int s0;
        int d0;
        int k0;
        int e0;
        logic [AW-1:0] rb;

        rst_n     = 1'b1;
        req       = 1'b0;
        base_addr = '0;
        len       = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {SF_CE0, SF_OE, SF_WE, SF_BYTE}, 4'b1110);
        chk("rst_sf_a", SF_A, 0);
        chk("rst_ctl", {busy, data_valid, done, err, tmr_start}, 0);
        chk("rst_data", data_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 3-byte burst, T = 4.
        dv_log.delete();
        start_burst(24'h000100, 3, 4, 0);
        wait_end(c, gd, ge);
        chk("t1_done", gd, 1);
        @(negedge clk);
        chk("t1_dv_count", dv_log.size(), 3);
        if (dv_log.size() == 3) begin
            chk("t1_first_latency", dv_log[0] - req_cyc, 7);
            chk("t1_spacing0", dv_log[1] - dv_log[0], 6);
            chk("t1_spacing1", dv_log[2] - dv_log[1], 6);
        end
        chk("t1_strobes_idle", {SF_CE0, SF_OE}, 2'b11);

        // Zero-length request.
        s0 = n_start;
        d0 = n_dv;
        k0 = n_ce_low;
        start_burst(24'h00ABCD, 0, 4, 0);
        wait_end(c, gd, ge);
        chk("len0_done", gd, 1);
        chk("len0_latency_le2", (c - req_cyc) <= 2, 1);
        @(negedge clk);
        chk("len0_no_start", n_start - s0, 0);
        chk("len0_no_data", n_dv - d0, 0);
        chk("len0_ce_high", n_ce_low - k0, 0);

        // Address wrap.
        sfa_log.delete();
        start_burst(24'hFFFFFF, 2, 3, 0);
        wait_end(c, gd, ge);
        chk("wrap_done", gd, 1);
        @(negedge clk);
        chk("wrap_sfa_count", sfa_log.size(), 2);
        if (sfa_log.size() == 2) begin
            chk("wrap_sfa0", sfa_log[0], 24'hFFFFFF);
            chk("wrap_sfa1", sfa_log[1], 24'h000000);
        end

        // Dead timer.
        d0 = n_dv;
        e0 = n_done;
        start_burst(24'h001234, 2, 100000, 1);
        wait_end(c, gd, ge);
        chk("dead_err", ge, 1);
        chk("dead_err_latency", c - last_start, TO);
        @(negedge clk);
        chk("dead_busy_low", busy, 0);
        chk("dead_strobes", {SF_CE0, SF_OE}, 2'b11);
        chk("dead_no_data", n_dv - d0, 0);
        chk("dead_no_done", n_done - e0, 0);

        // req pulsed mid-burst is ignored.
        d0 = n_dv;
        e0 = n_done;
        start_burst(24'h002000, 3, 5, 0);
        repeat (4) @(negedge clk);
        req       = 1'b1;
        base_addr = 24'h005555;
        len       = 16'd7;
        repeat (2) @(negedge clk);
        req = 1'b0;
        wait_end(c, gd, ge);
        chk("midreq_done", gd, 1);
        repeat (12) @(negedge clk);
        chk("midreq_idle", busy, 0);
        chk("midreq_bytes", n_dv - d0, 3);
        chk("midreq_one_done", n_done - e0, 1);

        // Asynchronous reset during WAIT of byte 2 of 4.
        s0 = n_start;
        start_burst(24'h003000, 4, 4, 0);
        for (int i = 0; i < 100 && n_start < s0 + 2; i++) @(negedge clk);
        chk("rstmid_reached_byte2", n_start - s0, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_strobes", {SF_CE0, SF_OE}, 2'b11);
        chk("rstmid_busy", busy, 0);
        exp_data.delete();
        exp_evt.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        start_burst(24'h0000AB, 1, 2, 0);
        wait_end(c, gd, ge);
        chk("rstmid_fresh_done", gd, 1);
        @(negedge clk);

        // Randomised bursts.
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rb = 24'hFFFFFF - AW'($urandom_range(0, 3));
            end else begin
                rb = AW'($urandom);
            end
            start_burst(rb, $urandom_range(0, 6), $urandom_range(1, 10), 0);
            wait_end(c, gd, ge);
            chk("rand_done", gd, 1);
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("final_data_drained", exp_data.size(), 0);
        chk("final_events_drained", exp_evt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
